// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_pkg                                              |
// | Description : Shared memory-bus wire types plus the arbiter register       |
// |               record, its reset constant and a small issue helper.         |
// | Contents    : mem_in_type   - request record (valid, fence, spec, instr,   |
// |                               addr, wdata, wstrb)                          |
// |               mem_out_type  - response record (ready, rdata)               |
// |               arb_state_type, arbiter_reg_type, init_arbiter_reg           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef struct packed {
      logic              mem_valid;
      logic              mem_fence;
      logic              mem_spec;
      logic              mem_instr;
      logic [ADDR_W-1:0] mem_addr;
      logic [DATA_W-1:0] mem_wdata;
      logic [STRB_W-1:0] mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic              mem_ready;
      logic [DATA_W-1:0] mem_rdata;
   } mem_out_type;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_type;

   typedef struct packed {
      arb_state_type state;
      logic          ipend;
      logic          dpend;
      mem_in_type    ireq;
      mem_in_type    dreq;
      mem_in_type    mem_in;
   } arbiter_reg_type;

   localparam mem_in_type C_MEM_IN_ZERO = '0;

   localparam arbiter_reg_type init_arbiter_reg = '{
      state  : ARB_IDLE,
      ipend  : 1'b0,
      dpend  : 1'b0,
      ireq   : C_MEM_IN_ZERO,
      dreq   : C_MEM_IN_ZERO,
      mem_in : C_MEM_IN_ZERO
   };

   // Builds the downstream request from a buffered one: the valid strobe is
   // regenerated and mem_instr is overwritten by the owning port, whatever
   // the requester originally placed in that field.
   function automatic mem_in_type issue_req(input mem_in_type req, input logic is_instr);
      mem_in_type res;
      res           = req;
      res.mem_valid = 1'b1;
      res.mem_instr = is_instr;
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Shares one downstream memory bus between the fetch          |
// |               (instruction) and decode (data) ports. Request pulses are    |
// |               buffered in one slot per port, issued one at a time with     |
// |               data priority, and responses are routed to the owner.        |
// | Ports       : clock    in  rising-edge clock                               |
// |               reset    in  synchronous active-low reset                    |
// |               imem_in  in  fetch request        imem_out out fetch resp    |
// |               dmem_in  in  data request         dmem_out out data resp     |
// |               mem_in   out downstream request (registered)                 |
// |               mem_out  in  downstream response                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  mem_in,
   input  mem_out_type mem_out
);

   arbiter_reg_type r_arb;
   arbiter_reg_type w_rin;

   // Next-state logic. A pulse always lands in its port's slot first, so a
   // pulse arriving while IDLE is issued straight from the updated slot in
   // the same cycle, and a pulse arriving during a completion is kept for
   // the following IDLE cycle.
   always_comb begin
      w_rin                  = r_arb;
      w_rin.mem_in.mem_valid = 1'b0;

      // A newer fetch simply overwrites a stale one (fetch redirect).
      if (imem_in.mem_valid) begin
         w_rin.ipend = 1'b1;
         w_rin.ireq  = imem_in;
      end
      if (dmem_in.mem_valid) begin
         w_rin.dpend = 1'b1;
         w_rin.dreq  = dmem_in;
      end

      case (r_arb.state)
         ARB_IDLE: begin
            if (w_rin.dpend) begin
               w_rin.mem_in = issue_req(w_rin.dreq, 1'b0);
               w_rin.dpend  = 1'b0;
               w_rin.state  = ARB_DBUSY;
            end else if (w_rin.ipend) begin
               w_rin.mem_in = issue_req(w_rin.ireq, 1'b1);
               w_rin.ipend  = 1'b0;
               w_rin.state  = ARB_IBUSY;
            end
         end
         ARB_IBUSY, ARB_DBUSY: begin
            // Request fields stay on mem_in until the response arrives.
            if (mem_out.mem_ready) begin
               w_rin.state = ARB_IDLE;
            end
         end
         default: begin
            w_rin.state = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_arb <= init_arbiter_reg;
      end else begin
         r_arb <= w_rin;
      end
   end

   // Response routing is combinational so the owner sees mem_ready in the
   // same cycle as the downstream bus. A ready seen in IDLE matches neither
   // owner and is dropped.
   always_comb begin
      imem_out.mem_ready = (r_arb.state == ARB_IBUSY) && mem_out.mem_ready;
      imem_out.mem_rdata = mem_out.mem_rdata;
      dmem_out.mem_ready = (r_arb.state == ARB_DBUSY) && mem_out.mem_ready;
      dmem_out.mem_rdata = mem_out.mem_rdata;
   end

   assign mem_in = r_arb.mem_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter: directed scenarios      |
// |               followed by random traffic against a transaction-level       |
// |               reference model (per-port slots, one owner, data priority).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   mem_in_type  imem_in;
   mem_in_type  dmem_in;
   mem_in_type  mem_in;
   mem_out_type imem_out;
   mem_out_type dmem_out;
   mem_out_type mem_out;

   int checks   = 0;
   int failures = 0;

   // Reference model: owner -1 = nothing outstanding, 0 = fetch, 1 = data.
   int         m_owner;
   bit         m_pend [2];
   mem_in_type m_req  [2];
   mem_in_type m_bus;
   bit         dec_out;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock    (clock),
      .reset    (reset),
      .imem_in  (imem_in),
      .imem_out (imem_out),
      .dmem_in  (dmem_in),
      .dmem_out (dmem_out),
      .mem_in   (mem_in),
      .mem_out  (mem_out)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mem_in_type rand_req();
      mem_in_type r;
      r.mem_valid = 1'b1;
      r.mem_fence = 1'($urandom_range(0, 1));
      r.mem_spec  = 1'($urandom_range(0, 1));
      r.mem_instr = 1'($urandom_range(0, 1));
      r.mem_addr  = $urandom;
      r.mem_wdata = $urandom;
      r.mem_wstrb = 4'($urandom_range(0, 15));
      return r;
   endfunction

   // Transaction-level step of the model: what the bus will carry next cycle.
   task automatic model_step();
      if (!reset) begin
         m_owner = -1;
         m_pend  = '{1'b0, 1'b0};
         m_req   = '{'0, '0};
         m_bus   = '0;
         dec_out = 1'b0;
         return;
      end
      m_bus.mem_valid = 1'b0;
      if (imem_in.mem_valid) begin m_pend[0] = 1'b1; m_req[0] = imem_in; end
      if (dmem_in.mem_valid) begin m_pend[1] = 1'b1; m_req[1] = dmem_in; end
      if (m_owner != -1) begin
         if (mem_out.mem_ready) m_owner = -1;
      end else begin
         for (int p = 1; p >= 0; p--) begin
            if (m_pend[p]) begin
               m_bus           = m_req[p];
               m_bus.mem_valid = 1'b1;
               m_bus.mem_instr = (p == 0);
               m_pend[p]       = 1'b0;
               m_owner         = p;
               break;
            end
         end
      end
   endtask

   // One clock cycle: check at the falling edge, advance the model, then
   // return just after the next rising edge with the one-cycle pulses cleared.
   task automatic tick();
      logic exp_ir, exp_dr;
      @(negedge clock);
      exp_ir = (m_owner == 0) && mem_out.mem_ready;
      exp_dr = (m_owner == 1) && mem_out.mem_ready;
      chk("mem_in", mem_in, m_bus);
      chk("imem_ready", imem_out.mem_ready, exp_ir);
      chk("dmem_ready", dmem_out.mem_ready, exp_dr);
      if (exp_ir) chk("imem_rdata", imem_out.mem_rdata, mem_out.mem_rdata);
      if (exp_dr) begin
         chk("dmem_rdata", dmem_out.mem_rdata, mem_out.mem_rdata);
         dec_out = 1'b0;
      end
      model_step();
      @(posedge clock);
      #1;
      imem_in.mem_valid = 1'b0;
      dmem_in.mem_valid = 1'b0;
      mem_out.mem_ready = 1'b0;
   endtask

   task automatic pulse_i(input logic [31:0] addr);
      imem_in           = '0;
      imem_in.mem_valid = 1'b1;
      imem_in.mem_addr  = addr;
   endtask

   task automatic pulse_d(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic fence);
      dmem_in           = '0;
      dmem_in.mem_valid = 1'b1;
      dmem_in.mem_fence = fence;
      dmem_in.mem_addr  = addr;
      dmem_in.mem_wdata = wdata;
      dmem_in.mem_wstrb = wstrb;
   endtask

   task automatic respond(input logic [31:0] rdata);
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = rdata;
   endtask

   initial begin
      imem_in = '0;
      dmem_in = '0;
      mem_out = '0;
      reset   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      m_owner = -1;
      m_pend  = '{1'b0, 1'b0};
      m_req   = '{'0, '0};
      m_bus   = '0;
      dec_out = 1'b0;

      // Reset state
      chk("rst_mem_in", mem_in, 72'h0);
      chk("rst_imem_out", imem_out, 33'h0);
      chk("rst_dmem_out", dmem_out, 33'h0);
      reset = 1'b1;
      tick();

      // Single fetch
      pulse_i(32'h100);
      tick();
      chk("fetch_valid", mem_in.mem_valid, 1'b1);
      chk("fetch_instr", mem_in.mem_instr, 1'b1);
      chk("fetch_addr", mem_in.mem_addr, 32'h100);
      tick();
      tick();
      respond(32'h0000_0013);
      #1;
      chk("fetch_iready", imem_out.mem_ready, 1'b1);
      chk("fetch_irdata", imem_out.mem_rdata, 32'h0000_0013);
      chk("fetch_dready", dmem_out.mem_ready, 1'b0);
      tick();
      tick();

      // Simultaneous pulses: data first, fetch two cycles after the first issue
      pulse_i(32'h200);
      pulse_d(32'h8000_0000, 32'h0, 4'h0, 1'b0);
      tick();
      chk("sim_d_addr", mem_in.mem_addr, 32'h8000_0000);
      chk("sim_d_instr", mem_in.mem_instr, 1'b0);
      chk("sim_d_wstrb", mem_in.mem_wstrb, 4'h0);
      respond(32'h1234_5678);
      tick();
      chk("sim_gap", mem_in.mem_valid, 1'b0);
      tick();
      chk("sim_i_valid", mem_in.mem_valid, 1'b1);
      chk("sim_i_addr", mem_in.mem_addr, 32'h200);
      respond(32'h0);
      tick();
      tick();

      // Data store arriving during a fetch
      pulse_i(32'h400);
      tick();
      pulse_d(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
      tick();
      tick();
      respond(32'h55);
      tick();
      tick();
      chk("dfetch_valid", mem_in.mem_valid, 1'b1);
      chk("dfetch_addr", mem_in.mem_addr, 32'h10);
      chk("dfetch_wdata", mem_in.mem_wdata, 32'hDEAD_BEEF);
      chk("dfetch_wstrb", mem_in.mem_wstrb, 4'hF);
      chk("dfetch_instr", mem_in.mem_instr, 1'b0);
      respond(32'h66);
      tick();
      tick();

      // Fetch redirect while DBUSY
      pulse_d(32'h20, 32'h0, 4'h0, 1'b0);
      tick();
      pulse_i(32'h300);
      tick();
      pulse_i(32'h304);
      tick();
      respond(32'h77);
      tick();
      tick();
      chk("redir_addr", mem_in.mem_addr, 32'h304);
      chk("redir_instr", mem_in.mem_instr, 1'b1);
      respond(32'h88);
      tick();
      tick();
      chk("redir_single", mem_in.mem_valid, 1'b0);
      tick();

      // Reset mid-DBUSY, then a late downstream ready
      pulse_d(32'h40, 32'h99, 4'h3, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("rst2_mem_in", mem_in, 72'h0);
      respond(32'h0);
      #1;
      chk("rst2_dready", dmem_out.mem_ready, 1'b0);
      chk("rst2_iready", imem_out.mem_ready, 1'b0);
      tick();
      pulse_i(32'h500);
      tick();
      chk("rst2_idle_issue", mem_in.mem_valid, 1'b1);
      respond(32'h0);
      tick();
      tick();

      // Fence
      pulse_d(32'h50, 32'h0, 4'h0, 1'b1);
      tick();
      chk("fence_valid", mem_in.mem_valid, 1'b1);
      chk("fence_flag", mem_in.mem_fence, 1'b1);
      tick();
      respond(32'h0);
      #1;
      chk("fence_dready", dmem_out.mem_ready, 1'b1);
      tick();
      tick();

      // Random traffic against the model
      dec_out = 1'b0;
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 3) == 0) imem_in = rand_req();
         if (!dec_out && $urandom_range(0, 4) == 0) begin
            dmem_in = rand_req();
            dec_out = 1'b1;
         end
         mem_out.mem_rdata = $urandom;
         if (m_owner != -1) mem_out.mem_ready = ($urandom_range(0, 2) == 0);
         else               mem_out.mem_ready = ($urandom_range(0, 9) == 0);
         tick();
      end
      reset = 1'b1;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
